w_sw_status_reporter: RTL and testbench

Transmit-side counterpart of the UART command decoder in the watch/stopwatch design. On a one-cycle report request it snapshots the displayed time and mode. It then emits one ASCII status frame, e.g. "W13:05:09\r\n", byte by byte into the TX FIFO push port using FIFO backpressure. It sits between the clock/stopwatch datapath and the TX FIFO, sharing that FIFO with the existing echo path through an upstream arbiter.

---
 rtl/w_sw_status_reporter.sv | 150 +++++++++++++++
 tb/tb_w_sw_status_reporter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/w_sw_status_reporter.sv
// Status frame transmitter: snapshots mode and time on a report request and
// pushes "Mhh:mm:ss" plus a line terminator into the TX FIFO under backpressure.
module w_sw_status_reporter #(
    parameter bit TERM_CRLF = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       report,
    input  logic       mode,
    input  logic [4:0] hour,
    input  logic [5:0] min,
    input  logic [5:0] sec,
    input  logic       full,
    output logic       push,
    output logic [7:0] push_data,
    output logic       busy,
    output logic       drop
);

    localparam logic [3:0] LAST = TERM_CRLF ? 4'd10 : 4'd9;

    typedef enum logic {
        S_IDLE,
        S_SEND
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [3:0] r_idx, w_idx_nxt;
    logic       r_pending, w_pending_nxt;
    logic       r_drop, w_drop_nxt;
    logic       w_load;
    logic       w_last;
    logic [7:0] w_byte;

    logic       r_mode;
    logic [4:0] r_hour;
    logic [5:0] r_min;
    logic [5:0] r_sec;

    function automatic logic [7:0] tens_ascii(input logic [5:0] v);
        return 8'h30 + 8'(v / 6'd10);
    endfunction

    function automatic logic [7:0] ones_ascii(input logic [5:0] v);
        return 8'h30 + 8'(v % 6'd10);
    endfunction

    // Byte selected by the frame index, built from the snapshot only.
    always_comb begin
        w_byte = 8'h00;
        case (r_idx)
            4'd0:    w_byte = r_mode ? 8'h53 : 8'h57;
            4'd1:    w_byte = tens_ascii({1'b0, r_hour});
            4'd2:    w_byte = ones_ascii({1'b0, r_hour});
            4'd3:    w_byte = 8'h3A;
            4'd4:    w_byte = tens_ascii(r_min);
            4'd5:    w_byte = ones_ascii(r_min);
            4'd6:    w_byte = 8'h3A;
            4'd7:    w_byte = tens_ascii(r_sec);
            4'd8:    w_byte = ones_ascii(r_sec);
            4'd9:    w_byte = TERM_CRLF ? 8'h0D : 8'h0A;
            4'd10:   w_byte = 8'h0A;
            default: w_byte = 8'h00;
        endcase
    end

    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_pending_nxt = r_pending;
        w_drop_nxt    = 1'b0;
        w_load        = 1'b0;
        w_last        = (r_idx == LAST);
        push          = 1'b0;
        busy          = 1'b0;
        push_data     = 8'h00;

        unique case (r_state)
            S_IDLE: begin
                if (report) begin
                    w_state_nxt = S_SEND;
                    w_idx_nxt   = 4'd0;
                    w_load      = 1'b1;
                end
            end
            S_SEND: begin
                busy      = 1'b1;
                push      = ~full;
                push_data = w_byte;
                if (push && w_last) begin
                    // A request on the closing edge chains the next frame with no gap.
                    w_idx_nxt = 4'd0;
                    if (r_pending || report) begin
                        w_load        = 1'b1;
                        w_pending_nxt = r_pending & report;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    if (push) begin
                        w_idx_nxt = r_idx + 4'd1;
                    end
                    if (report) begin
                        if (r_pending) begin
                            w_drop_nxt = 1'b1;
                        end else begin
                            w_pending_nxt = 1'b1;
                        end
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_idx     <= 4'd0;
            r_pending <= 1'b0;
            r_drop    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_pending <= w_pending_nxt;
            r_drop    <= w_drop_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode <= 1'b0;
            r_hour <= 5'd0;
            r_min  <= 6'd0;
            r_sec  <= 6'd0;
        end else if (w_load) begin
            r_mode <= mode;
            r_hour <= hour;
            r_min  <= min;
            r_sec  <= sec;
        end
    end

    assign drop = r_drop;

endmodule

// File: tb/tb_w_sw_status_reporter.sv
// Scoreboard bench for w_sw_status_reporter: CRLF and LF-only instances share
// stimulus; a frame-level model queues expected bytes, a negedge monitor pops them.
module tb_w_sw_status_reporter;

    logic       clk = 1'b0;
    logic       rst;
    logic       report;
    logic       mode;
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
    logic       full;

    logic       push0, busy0, drop0;
    logic       push1, busy1, drop1;
    logic [7:0] data0, data1;

    int n_total = 0;
    int n_pass  = 0;

    bit         m_busy[2];
    bit         m_pending[2];
    bit         m_drop[2];
    int         m_left[2];
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    always #5 clk = ~clk;

    w_sw_status_reporter #(.TERM_CRLF(1'b1)) dut0 (
        .clk(clk), .rst(rst), .report(report), .mode(mode), .hour(hour),
        .min(min), .sec(sec), .full(full), .push(push0), .push_data(data0),
        .busy(busy0), .drop(drop0)
    );

    w_sw_status_reporter #(.TERM_CRLF(1'b0)) dut1 (
        .clk(clk), .rst(rst), .report(report), .mode(mode), .hour(hour),
        .min(min), .sec(sec), .full(full), .push(push1), .push_data(data1),
        .busy(busy1), .drop(drop1)
    );

    task automatic check(input string name, input int actual, input int expected);
        n_total++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    endtask

    // Expected frame text for instance k from the current inputs.
    function automatic void push_frame(input int k);
        int         n[3];
        logic [7:0] f[$];
        logic [7:0] pfx;
        n[0] = int'(hour);
        n[1] = int'(min);
        n[2] = int'(sec);
        pfx  = mode ? "S" : "W";
        f.push_back(pfx);
        for (int i = 0; i < 3; i++) begin
            f.push_back(8'(48 + n[i] / 10));
            f.push_back(8'(48 + n[i] % 10));
            if (i < 2) f.push_back(":");
        end
        if (k == 0) f.push_back(8'h0D);
        f.push_back(8'h0A);
        m_left[k] = f.size();
        foreach (f[i]) begin
            if (k == 0) q0.push_back(f[i]);
            else        q1.push_back(f[i]);
        end
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_busy[k]    = 1'b0;
            m_pending[k] = 1'b0;
            m_drop[k]    = 1'b0;
            m_left[k]    = 0;
        end
        q0.delete();
        q1.delete();
    endfunction

    // Frame-level behaviour at one clock edge, using the inputs sampled there.
    function automatic void model_edge();
        for (int k = 0; k < 2; k++) begin
            m_drop[k] = 1'b0;
            if (!m_busy[k]) begin
                if (report) begin
                    m_busy[k] = 1'b1;
                    push_frame(k);
                end
            end else if (!full && m_left[k] == 1) begin
                if (m_pending[k] || report) begin
                    push_frame(k);
                    m_pending[k] = m_pending[k] && report;
                end else begin
                    m_busy[k] = 1'b0;
                end
            end else begin
                if (!full) m_left[k]--;
                if (report) begin
                    if (m_pending[k]) m_drop[k] = 1'b1;
                    else              m_pending[k] = 1'b1;
                end
            end
        end
    endfunction

    task automatic check_one(input int k, input logic p, input logic [7:0] d,
                             input logic b, input logic dr);
        logic [7:0] e;
        check($sformatf("push%0d", k), int'(p), int'(m_busy[k] && !full));
        check($sformatf("busy%0d", k), int'(b), int'(m_busy[k]));
        check($sformatf("drop%0d", k), int'(dr), int'(m_drop[k]));
        if (!m_busy[k]) begin
            check($sformatf("idle_data%0d", k), int'(d), 0);
        end else if (p) begin
            if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
                n_total++;
                $display("FAIL byte%0d: got unexpected 0x%0h expected no byte at %0t", k, d, $time);
            end else begin
                e = (k == 0) ? q0.pop_front() : q1.pop_front();
                check($sformatf("byte%0d", k), int'(d), int'(e));
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            check("rst_push0", int'(push0), 0);
            check("rst_busy0", int'(busy0), 0);
            check("rst_push1", int'(push1), 0);
            check("rst_busy1", int'(busy1), 0);
            check("rst_data0", int'(data0), 0);
        end else begin
            check_one(0, push0, data0, busy0, drop0);
            check_one(1, push1, data1, busy1, drop1);
        end
    end

    task automatic cyc(input bit rep, input bit f);
        report = rep;
        full   = f;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_fields(input bit md, input int h, input int m, input int s);
        mode = md;
        hour = 5'(h);
        min  = 6'(m);
        sec  = 6'(s);
    endtask

    initial begin
        int guard;
        rst    = 1'b1;
        report = 1'b0;
        full   = 1'b0;
        set_fields(0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Basic frame W13:05:09
        set_fields(0, 13, 5, 9);
        cyc(1, 0);
        repeat (12) cyc(0, 0);

        // Backpressure at index 4 for three cycles
        cyc(1, 0);
        repeat (4) cyc(0, 0);
        repeat (3) cyc(0, 1);
        repeat (12) cyc(0, 0);

        // Snapshot holds while inputs change mid-frame
        cyc(1, 0);
        sec = 6'd10;
        repeat (12) cyc(0, 0);

        // Queueing: pending request, then a discarded one
        set_fields(0, 13, 5, 9);
        cyc(1, 0);
        repeat (3) cyc(0, 0);
        set_fields(1, 7, 42, 3);
        cyc(1, 0);
        repeat (2) cyc(0, 0);
        set_fields(0, 22, 22, 22);
        cyc(1, 0);
        repeat (25) cyc(0, 0);

        // Request landing on the closing edge of the CRLF frame
        set_fields(0, 31, 63, 63);
        cyc(1, 0);
        repeat (10) cyc(0, 0);
        set_fields(1, 1, 2, 3);
        cyc(1, 0);
        repeat (25) cyc(0, 0);

        // Stopwatch frame S00:59:59
        set_fields(1, 0, 59, 59);
        cyc(1, 0);
        repeat (12) cyc(0, 0);

        // Reset at index 5 abandons the frame; a fresh report restarts cleanly
        set_fields(0, 13, 5, 9);
        cyc(1, 0);
        repeat (5) cyc(0, 0);
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cyc(1, 0);
        repeat (12) cyc(0, 0);

        // Random traffic
        repeat (3000) begin
            mode = 1'($urandom);
            hour = 5'($urandom);
            min  = 6'($urandom);
            sec  = 6'($urandom);
            cyc($urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0);
        end

        // Drain, bounded
        guard = 0;
        while ((m_busy[0] || m_busy[1]) && guard < 100) begin
            cyc(0, 0);
            guard++;
        end
        @(negedge clk);
        #1;
        check("drain_done", guard < 100 ? 1 : 0, 1);
        check("q0_empty", q0.size(), 0);
        check("q1_empty", q1.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
